// File: rtl/spi_register_controller.sv
// Command sequencer and register bank behind an SPI command slave; the bank is
// shared with a local fabric requester through a fixed-priority single-port arbiter.
module spi_register_controller #(
    parameter int                   WORD_SIZE    = 32,
    parameter int                   COMMAND_SIZE = 8,
    parameter int                   NUM_REGS     = 8,
    parameter logic [WORD_SIZE-1:0] ID_VALUE     = 32'h5049434F
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [COMMAND_SIZE-1:0]           command,
    input  logic                              command_ready,
    input  logic [WORD_SIZE-1:0]              word_received,
    input  logic                              word_rx_complete,
    input  logic                              spi_cs,
    output logic [WORD_SIZE-1:0]              word_to_output,
    input  logic                              local_req,
    input  logic                              local_we,
    input  logic [$clog2(NUM_REGS)-1:0]       local_addr,
    input  logic [WORD_SIZE-1:0]              local_wdata,
    output logic                              local_ack,
    output logic [WORD_SIZE-1:0]              local_rdata,
    output logic [(NUM_REGS-1)*WORD_SIZE-1:0] ctrl_regs,
    output logic                              spi_write_strobe,
    output logic [7:0]                        abort_count
);
    localparam int IDX_W  = COMMAND_SIZE - 1;
    localparam int BANK_W = (NUM_REGS - 1) * WORD_SIZE;
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, STAGED, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cmd_idx_q, cmd_idx_d;
    logic                 cmd_wr_q, cmd_wr_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [BANK_W-1:0]    regs_q, regs_d;
    logic [WORD_SIZE-1:0] word_out_q, word_out_d;
    logic                 ack_q, ack_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 strobe_q, strobe_d;
    logic [7:0]           abort_q, abort_d;

    logic                 decode, bump_abort, spi_busy;
    logic [IDX_W-1:0]     loc_idx;

    // Register 0 is the constant ID; anything past the bank reads as zero.
    function automatic logic [WORD_SIZE-1:0] read_bank(input logic [IDX_W-1:0] idx,
                                                       input logic [BANK_W-1:0] bank);
        logic [WORD_SIZE-1:0] val;
        val = '0;
        if (idx == '0) val = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) val = bank[(i-1)*WORD_SIZE +: WORD_SIZE];
        end
        return val;
    endfunction

    function automatic logic is_rw(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < REG_LIMIT) && (idx != '0);
    endfunction

    assign loc_idx = IDX_W'(local_addr);

    always_comb begin
        state_d    = state_q;
        cmd_idx_d  = cmd_idx_q;
        cmd_wr_d   = cmd_wr_q;
        wr_pend_d  = wr_pend_q;
        wdata_d    = wdata_q;
        regs_d     = regs_q;
        word_out_d = word_out_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        strobe_d   = 1'b0;
        abort_d    = abort_q;
        decode     = 1'b0;
        bump_abort = 1'b0;

        case (state_q)
            IDLE: begin
                if (command_ready) decode = 1'b1;
            end
            STAGED: begin
                // A fresh command mid-word abandons the old one and restarts decode.
                if (command_ready) begin
                    bump_abort = 1'b1;
                    decode     = 1'b1;
                end else if (word_rx_complete) begin
                    state_d = COMMIT;
                    if (cmd_wr_q && is_rw(cmd_idx_q)) begin
                        wr_pend_d = 1'b1;
                        wdata_d   = word_received;
                    end
                end else if (spi_cs) begin
                    bump_abort = 1'b1;
                    state_d    = IDLE;
                end
            end
            COMMIT: begin
                state_d   = IDLE;
                wr_pend_d = 1'b0;
                if (wr_pend_q) begin
                    strobe_d = 1'b1;
                    for (int i = 1; i < NUM_REGS; i++) begin
                        if (cmd_idx_q == IDX_W'(i)) regs_d[(i-1)*WORD_SIZE +: WORD_SIZE] = wdata_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (decode) begin
            state_d    = STAGED;
            cmd_idx_d  = command[IDX_W-1:0];
            cmd_wr_d   = command[COMMAND_SIZE-1];
            wr_pend_d  = 1'b0;
            word_out_d = read_bank(command[IDX_W-1:0], regs_q);
        end

        if (bump_abort && (abort_q != 8'hFF)) abort_d = abort_q + 8'd1;

        // SPI owns the bank port on decode and commit cycles; the ack cycle is
        // skipped so a request still held high is not serviced twice.
        spi_busy = decode || (state_q == COMMIT);
        if (local_req && !spi_busy && !ack_q) begin
            ack_d   = 1'b1;
            rdata_d = read_bank(loc_idx, regs_q);
            if (local_we) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (loc_idx == IDX_W'(i)) regs_d[(i-1)*WORD_SIZE +: WORD_SIZE] = local_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_idx_q  <= '0;
            cmd_wr_q   <= 1'b0;
            wr_pend_q  <= 1'b0;
            wdata_q    <= '0;
            regs_q     <= '0;
            word_out_q <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            strobe_q   <= 1'b0;
            abort_q    <= '0;
        end else begin
            state_q    <= state_d;
            cmd_idx_q  <= cmd_idx_d;
            cmd_wr_q   <= cmd_wr_d;
            wr_pend_q  <= wr_pend_d;
            wdata_q    <= wdata_d;
            regs_q     <= regs_d;
            word_out_q <= word_out_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            strobe_q   <= strobe_d;
            abort_q    <= abort_d;
        end
    end

    assign word_to_output   = word_out_q;
    assign local_ack        = ack_q;
    assign local_rdata      = rdata_q;
    assign ctrl_regs        = regs_q;
    assign spi_write_strobe = strobe_q;
    assign abort_count      = abort_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// Randomized self-checking bench for spi_register_controller against a
// transaction-level model of the register bank and abort counter.
module tb_spi_register_controller;
    localparam int          W  = 32;
    localparam int          NR = 8;
    localparam logic [31:0] ID = 32'h5049434F;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           command = '0;
    logic                 command_ready = 1'b0;
    logic [W-1:0]         word_received = '0;
    logic                 word_rx_complete = 1'b0;
    logic                 spi_cs = 1'b0;
    logic [W-1:0]         word_to_output;
    logic                 local_req = 1'b0;
    logic                 local_we = 1'b0;
    logic [2:0]           local_addr = '0;
    logic [W-1:0]         local_wdata = '0;
    logic                 local_ack;
    logic [W-1:0]         local_rdata;
    logic [(NR-1)*W-1:0]  ctrl_regs;
    logic                 spi_write_strobe;
    logic [7:0]           abort_count;

    always #5 clk = ~clk;

    spi_register_controller dut (
        .clk(clk), .rst_n(rst_n),
        .command(command), .command_ready(command_ready),
        .word_received(word_received), .word_rx_complete(word_rx_complete),
        .spi_cs(spi_cs), .word_to_output(word_to_output),
        .local_req(local_req), .local_we(local_we), .local_addr(local_addr),
        .local_wdata(local_wdata), .local_ack(local_ack), .local_rdata(local_rdata),
        .ctrl_regs(ctrl_regs), .spi_write_strobe(spi_write_strobe),
        .abort_count(abort_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_regs [0:NR-1];
    int          m_abort = 0;
    logic [7:0]  cur_cmd;
    logic [31:0] cur_exp;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input int idx);
        if (idx == 0) return ID;
        if (idx < NR) return m_regs[idx];
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_abort = 0;
    endtask

    task automatic model_abort();
        m_abort = (m_abort < 255) ? m_abort + 1 : 255;
    endtask

    task automatic check_bank(input string tag);
        for (int i = 1; i < NR; i++)
            chk_eq($sformatf("%s_r%0d", tag, i), ctrl_regs[(i-1)*W +: W], m_regs[i]);
    endtask

    task automatic spi_cmd(input logic [7:0] cmd);
        logic [31:0] e;
        e = exp_read(int'(cmd[6:0]));
        command = cmd;
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
        chk_eq("rdback", word_to_output, e);
        cur_cmd = cmd;
        cur_exp = e;
    endtask

    task automatic local_acc(input bit we, input logic [2:0] addr, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        local_we = we;
        local_addr = addr;
        local_wdata = wd;
        local_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (local_ack) begin
                got = 1'b1;
                break;
            end
        end
        local_req = 1'b0;
        chk_eq("local_ack", 32'(local_ack), 32'd1);
        if (got) begin
            if (!we) chk_eq("local_rdata", local_rdata, exp_read(int'(addr)));
            else if (addr != 3'd0) m_regs[addr] = wd;
        end
        tick();
        chk_eq("local_ack_pulse", 32'(local_ack), 32'd0);
    endtask

    task automatic spi_finish(input logic [31:0] data, input bit abort, input bit raw);
        int idx;
        bit legal;
        idx = int'(cur_cmd[6:0]);
        legal = cur_cmd[7] && (idx >= 1) && (idx < NR);
        repeat ($urandom_range(0, 2)) tick();
        chk_eq("rdback_hold", word_to_output, cur_exp);
        if (abort) begin
            spi_cs = 1'b1;
            tick();
            spi_cs = 1'b0;
            model_abort();
            chk_eq("abort_cnt", 32'(abort_count), 32'(m_abort));
            tick();
            chk_eq("abort_no_strobe", 32'(spi_write_strobe), 32'd0);
        end else begin
            word_received = data;
            word_rx_complete = 1'b1;
            tick();
            word_rx_complete = 1'b0;
            chk_eq("strobe_early", 32'(spi_write_strobe), 32'd0);
            tick();
            chk_eq("strobe", 32'(spi_write_strobe), 32'(legal));
            if (legal) m_regs[idx] = data;
            if (raw && legal) begin
                local_acc(1'b0, 3'(idx), 32'h0);
            end else begin
                tick();
                chk_eq("strobe_len", 32'(spi_write_strobe), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] d;
        logic [7:0]  cmd;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_word", word_to_output, 32'h0);
        chk_eq("rst_ack", 32'(local_ack), 32'd0);
        chk_eq("rst_rdata", local_rdata, 32'h0);
        chk_eq("rst_strobe", 32'(spi_write_strobe), 32'd0);
        chk_eq("rst_abort", 32'(abort_count), 32'd0);
        check_bank("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ID read, held across the staging window
        spi_cmd(8'h00);
        chk_eq("id_value", word_to_output, ID);
        spi_finish(32'h11111111, 1'b0, 1'b0);

        // write then read back register 3
        spi_cmd(8'h83);
        spi_finish(32'hCAFEF00D, 1'b0, 1'b1);
        chk_eq("reg3_bus", ctrl_regs[95:64], 32'hCAFEF00D);
        spi_cmd(8'h03);
        chk_eq("reg3_rdback", word_to_output, 32'hCAFEF00D);
        spi_finish(32'h0, 1'b0, 1'b0);

        // chip-select abort
        spi_cmd(8'h85);
        spi_finish(32'hDEADBEEF, 1'b1, 1'b0);
        chk_eq("abort_one", 32'(abort_count), 32'd1);
        check_bank("abort");

        // local write colliding with an SPI command
        e = exp_read(2);
        command = 8'h02;
        command_ready = 1'b1;
        local_req = 1'b1;
        local_we = 1'b1;
        local_addr = 3'd2;
        local_wdata = 32'h12345678;
        tick();
        command_ready = 1'b0;
        chk_eq("arb_rdback", word_to_output, e);
        chk_eq("arb_blocked", 32'(local_ack), 32'd0);
        tick();
        chk_eq("arb_ack_late", 32'(local_ack), 32'd1);
        local_req = 1'b0;
        m_regs[2] = 32'h12345678;
        chk_eq("arb_reg2", ctrl_regs[63:32], 32'h12345678);
        chk_eq("arb_rdback_kept", word_to_output, e);
        cur_cmd = 8'h02;
        cur_exp = e;
        spi_finish(32'h0, 1'b0, 1'b0);

        // writes to the ID register and beyond the bank are dropped
        spi_cmd(8'h80);
        spi_finish(32'hAAAA5555, 1'b0, 1'b0);
        spi_cmd(8'h8A);
        spi_finish(32'h5555AAAA, 1'b0, 1'b0);
        check_bank("illegal");
        spi_cmd(8'h0A);
        chk_eq("oob_read", word_to_output, 32'h0);
        spi_finish(32'h0, 1'b0, 1'b0);
        local_acc(1'b1, 3'd0, 32'hFFFFFFFF);
        local_acc(1'b0, 3'd0, 32'h0);

        // new command while staged counts as an abort and re-decodes
        spi_cmd(8'h84);
        model_abort();
        spi_cmd(8'h01);
        chk_eq("restage_abort", 32'(abort_count), 32'(m_abort));
        spi_finish(32'h0, 1'b0, 1'b0);

        // completion and chip-select in the same cycle: completion wins
        spi_cmd(8'h86);
        d = $urandom;
        word_received = d;
        word_rx_complete = 1'b1;
        spi_cs = 1'b1;
        tick();
        word_rx_complete = 1'b0;
        spi_cs = 1'b0;
        tick();
        chk_eq("race_strobe", 32'(spi_write_strobe), 32'd1);
        m_regs[6] = d;
        chk_eq("race_abort", 32'(abort_count), 32'(m_abort));
        check_bank("race");

        // randomized mix of SPI transactions and local accesses
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))};
                spi_cmd(cmd);
                spi_finish($urandom, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            end else begin
                local_acc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
            end
        end
        check_bank("rand");
        chk_eq("rand_abort", 32'(abort_count), 32'(m_abort));

        // saturation of the abort counter
        for (int n = 0; n < 300; n++) begin
            spi_cmd(8'h85);
            spi_finish($urandom, 1'b1, 1'b0);
        end
        chk_eq("abort_sat", 32'(abort_count), 32'd255);
        chk_eq("abort_reg5", ctrl_regs[159:128], m_regs[5]);

        // reset while a write is staged
        spi_cmd(8'h81);
        #2;
        rst_n = 1'b0;
        #2;
        model_reset();
        chk_eq("mid_rst_word", word_to_output, 32'h0);
        chk_eq("mid_rst_abort", 32'(abort_count), 32'd0);
        chk_eq("mid_rst_strobe", 32'(spi_write_strobe), 32'd0);
        check_bank("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_bank("post_rst");
        spi_cmd(8'h81);
        spi_finish(32'h0BADF00D, 1'b0, 1'b1);
        chk_eq("post_rst_reg1", ctrl_regs[31:0], 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/spi_register_controller.md
Name: spi_register_controller

Overview:
- Sequences the SPI command slave's control interface and owns a small register bank on the far side of it.
- Decodes each received command byte and stages the read-back word inside the slave's two-cycle staging window.
- Commits write data when the data word completes, and aborts cleanly if chip-select rises mid-word.
- Shares the register bank with a local fabric requester through a fixed-priority single-port arbiter.

Parameters:
- WORD_SIZE, 32: data word width.
- COMMAND_SIZE, 8: command byte width. Bit [COMMAND_SIZE-1] = write flag; lower bits = register index.
- NUM_REGS, 8: register count. Index 0 is read-only ID; indices 1..NUM_REGS-1 are read/write.
- ID_VALUE, 32'h5049434F: value returned by register 0.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- command  in  COMMAND_SIZE  command byte from the SPI slave.
- command_ready  in  1  one-cycle pulse; command is valid in this cycle.
- word_received  in  WORD_SIZE  data word from the SPI slave.
- word_rx_complete  in  1  one-cycle pulse; word_received is valid in this cycle.
- spi_cs  in  1  raw chip-select, active low, synchronized upstream.
- word_to_output  out  WORD_SIZE  read-back word. Integration zero-pads to the slave's port width.
- local_req  in  1  local access request; held until local_ack.
- local_we  in  1  local write enable.
- local_addr  in  $clog2(NUM_REGS)  local register index.
- local_wdata  in  WORD_SIZE  local write data.
- local_ack  out  1  one-cycle completion pulse.
- local_rdata  out  WORD_SIZE  read data; valid with local_ack.
- ctrl_regs  out  (NUM_REGS-1)*WORD_SIZE  flat bus of registers 1..NUM_REGS-1; register 1 in the LSBs.
- spi_write_strobe  out  1  one-cycle pulse on each committed SPI write.
- abort_count  out  8  saturating count of aborted SPI transactions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - All RW registers = 0.
  - word_to_output = 0, local_ack = 0, local_rdata = 0, spi_write_strobe = 0, abort_count = 0.
  - Reset mid-transaction discards the pending write.
- Decode:
  - idx = command[COMMAND_SIZE-2:0]; wr = command[COMMAND_SIZE-1].
  - idx >= NUM_REGS is illegal: read-back 0, write dropped, no strobe.
  - Writes to idx 0 are dropped.
- FSM states: IDLE, STAGED, COMMIT.
  - IDLE, command_ready=1: latch idx/wr and go to STAGED. word_to_output is registered with the read value in this edge (ID_VALUE, register contents, or 0), so it is valid the following cycle. Latency is exactly 1 clock; the slave samples it in its second staging cycle.
  - STAGED, word_rx_complete=1: go to COMMIT, latching word_received if wr and the target is legal and non-zero.
  - STAGED, spi_cs=1 without word_rx_complete: go to IDLE and increment abort_count (saturates at 255). No write occurs.
  - STAGED, command_ready=1: treated as abort (abort_count+1), then the new command is decoded as from IDLE, all in the same cycle.
  - STAGED, simultaneous word_rx_complete and spi_cs=1: completion wins; no abort.
  - COMMIT: write the register and pulse spi_write_strobe (only for a legal write). Return to IDLE unconditionally after 1 cycle.
- Arbitration: the bank accepts one access per cycle.
  - SPI read (IDLE with command_ready) and SPI write (COMMIT) have priority.
  - A local request is served in any cycle without an SPI access. local_ack and local_rdata are registered, one cycle after service.
  - A blocked local request waits; it is never dropped.
  - Local access follows the same rules: idx 0 returns ID_VALUE, writes to idx 0 are ignored, and out-of-range reads return 0.
- Read-after-write: a local read of a register in the cycle after its COMMIT returns the new value. The SPI read-back reflects register contents at the command_ready edge.
- ctrl_regs reflects register contents combinationally from the registers; there is no added latency.

Test Plan:
- Reset, then command_ready with command 0x00 → word_to_output = 0x5049434F one cycle later, held until the next command.
- Command 0x83, word_rx_complete with 0xCAFEF00D → spi_write_strobe 2 cycles after the data pulse; ctrl_regs[95:64] = 0xCAFEF00D; a following command 0x03 reads back 0xCAFEF00D.
- Command 0x85, spi_cs rises before word_rx_complete → abort_count = 1, register 5 unchanged, state IDLE. Repeat 300 times → abort_count = 255.
- local_req write to register 2 (0x12345678) asserted in the same cycle as SPI command_ready → local_ack delayed by one cycle, then register 2 = 0x12345678; the SPI read-back is unaffected.
- Commands 0x80 and 0x8A (NUM_REGS=8) each followed by a data word → no strobe, all registers unchanged; command 0x0A read-back = 0.
- rst_n pulsed low while in STAGED after command 0x81 → no write; registers = 0; the next transaction behaves normally.
